// File: rtl/fru_pla_pkg.sv
// Shared types and configuration-layout helpers for the segmented FRU select PLA.
package fru_pla_pkg;

    typedef enum logic [1:0] {
        FRU_MODE_LEVEL  = 2'b00,
        FRU_MODE_STICKY = 2'b01,
        FRU_MODE_EDGE   = 2'b10,
        FRU_MODE_OFF    = 2'b11
    } fruMode_e;

    localparam int SEG_DEFAULT = 4;

    typedef struct packed {
        logic                   en;
        logic [SEG_DEFAULT-1:0] neg;
        logic [SEG_DEFAULT-1:0] pos;
    } fruTerm_t;

    function automatic int termW(input int seg);
        return 1 + 2 * seg;
    endfunction

    function automatic int selW(input int seg, input int nTerms);
        return 2 + nTerms * termW(seg);
    endfunction

    function automatic int cfgWidth(input int seg, input int nTerms, input int nOut);
        return nOut * selW(seg, nTerms);
    endfunction

endpackage

// File: rtl/fru_pla_segment.sv
// One select's product terms over its trigger slice, ORed into a raw select.
module fru_pla_segment
    import fru_pla_pkg::*;
#(
    parameter int SEGMENT_SIZE = 4,
    parameter int NUM_TERMS    = 4
) (
    input  logic [SEGMENT_SIZE-1:0]                     Trig,
    input  logic [NUM_TERMS*termW(SEGMENT_SIZE)-1:0]    Terms,
    output logic                                        Raw
);

    localparam int TW = termW(SEGMENT_SIZE);

    // A set pos bit requires the trigger high, a set neg bit requires it low.
    function automatic logic termHit(input logic [TW-1:0] term, input logic [SEGMENT_SIZE-1:0] t);
        logic [SEGMENT_SIZE-1:0] pos;
        logic [SEGMENT_SIZE-1:0] neg;
        pos = term[SEGMENT_SIZE-1:0];
        neg = term[2*SEGMENT_SIZE-1:SEGMENT_SIZE];
        return term[TW-1] & (&((~pos | t) & (~neg | ~t)));
    endfunction

    always_comb begin
        Raw = 1'b0;
        for (int k = 0; k < NUM_TERMS; k++) begin
            Raw = Raw | termHit(Terms[k*TW +: TW], Trig);
        end
    end

endmodule

// File: rtl/fru_seg_pla_cfg.sv
// Segmented PLA with serial shadow configuration, atomic commit and per-select output modes.
module fru_seg_pla_cfg
    import fru_pla_pkg::*;
#(
    parameter int INPUT_SIZE   = 8,
    parameter int OUTPUT_SIZE  = 4,
    parameter int SEGMENT_SIZE = 4,
    parameter int NUM_TERMS    = 4
) (
    input  logic                   Clk,
    input  logic                   RstN,
    input  logic [INPUT_SIZE-1:0]  Trigger,
    input  logic                   CfgEn,
    input  logic                   CfgBit,
    input  logic                   CfgCommit,
    input  logic                   StickyClr,
    output logic [OUTPUT_SIZE-1:0] FruSelect,
    output logic                   CfgReady,
    output logic                   CfgErr
);

    localparam int TW    = termW(SEGMENT_SIZE);
    localparam int SW    = selW(SEGMENT_SIZE, NUM_TERMS);
    localparam int CW    = cfgWidth(SEGMENT_SIZE, NUM_TERMS, OUTPUT_SIZE);
    localparam int NSEG  = INPUT_SIZE / SEGMENT_SIZE;
    localparam int CNT_W = $clog2(CW + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CW + 1);

    logic [CW-1:0]          shadow;
    logic [CW-1:0]          active;
    logic [CNT_W-1:0]       cfgCnt;
    logic [OUTPUT_SIZE-1:0] raw;
    logic [OUTPUT_SIZE-1:0] sticky;
    logic [OUTPUT_SIZE-1:0] prevRaw;
    logic [OUTPUT_SIZE-1:0] stickyNext;
    logic [OUTPUT_SIZE-1:0] selNext;
    logic                   commitOk;

    assign CfgReady = (cfgCnt == CNT_FULL);
    assign commitOk = CfgCommit & CfgReady & ~CfgEn;

    for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : gSel
        fru_pla_segment #(
            .SEGMENT_SIZE(SEGMENT_SIZE),
            .NUM_TERMS   (NUM_TERMS)
        ) uSeg (
            .Trig (Trigger[(j % NSEG)*SEGMENT_SIZE +: SEGMENT_SIZE]),
            .Terms(active[j*SW +: NUM_TERMS*TW]),
            .Raw  (raw[j])
        );
    end

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        stickyNext = raw | (sticky & ~{OUTPUT_SIZE{StickyClr}});
        selNext    = '0;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            case (fruMode_e'(active[j*SW + SW - 2 +: 2]))
                FRU_MODE_LEVEL:  selNext[j] = raw[j];
                FRU_MODE_STICKY: selNext[j] = stickyNext[j];
                FRU_MODE_EDGE:   selNext[j] = raw[j] & ~prevRaw[j];
                default:         selNext[j] = 1'b0;
            endcase
        end
    end

    // The output at a commit edge is still computed from the outgoing config.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            shadow    <= '0;
            active    <= '0;
            cfgCnt    <= '0;
            sticky    <= '0;
            prevRaw   <= '0;
            FruSelect <= '0;
            CfgErr    <= 1'b0;
        end else begin
            FruSelect <= selNext;
            if (CfgEn) begin
                shadow <= {shadow[CW-2:0], CfgBit};
                if (cfgCnt != CNT_SAT) begin
                    cfgCnt <= cfgCnt + 1'b1;
                end
            end
            if (commitOk) begin
                active  <= shadow;
                cfgCnt  <= '0;
                sticky  <= '0;
                prevRaw <= '0;
                CfgErr  <= 1'b0;
            end else begin
                sticky  <= stickyNext;
                prevRaw <= raw;
                if (CfgCommit) begin
                    CfgErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fru_seg_pla_cfg.md
Name: fru_seg_pla_cfg

Overview:
Field-programmable, segmented PLA that turns trigger signals into FRU select signals.
- Each select output owns one SEGMENT_SIZE-wide slice of the trigger bus, NUM_TERMS programmable minterms and an output mode (level, sticky or rising-edge pulse).
- Configuration is shifted in serially into a shadow register and committed atomically into the active register.
- Sits between trigger generation and the FRU control datapath.

Parameters:
INPUT_SIZE, 8, trigger bus width; must be a multiple of SEGMENT_SIZE
OUTPUT_SIZE, 4, number of FruSelect outputs
SEGMENT_SIZE, 4, triggers seen by each select
NUM_TERMS, 4, minterms ORed per select

Ports:
Clk  in  1  block clock
RstN  in  1  asynchronous active-low reset
Trigger  in  INPUT_SIZE  trigger inputs, synchronous to Clk
CfgEn  in  1  shift CfgBit into the shadow chain this cycle
CfgBit  in  1  serial configuration data
CfgCommit  in  1  request copy of shadow into active configuration
StickyClr  in  1  clear all sticky-mode outputs
FruSelect  out  OUTPUT_SIZE  registered select outputs
CfgReady  out  1  shadow holds exactly CFG_WIDTH bits since the last commit
CfgErr  out  1  sticky flag: a commit was rejected

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Configuration layout:
  - TERM_W = 1+2*SEGMENT_SIZE.
  - SEL_W = 2+NUM_TERMS*TERM_W.
  - CFG_WIDTH = OUTPUT_SIZE*SEL_W.
  - Select j occupies shadow[j*SEL_W +: SEL_W].
  - Within a select field: bits [1:0] of the top are mode at MSBs, then term NUM_TERMS-1 down to term0.
  - Each term is {en, neg[SEG-1:0], pos[SEG-1:0]}, with en at the MSB.
- Segment mapping: select j uses Trigger[(j % (INPUT_SIZE/SEGMENT_SIZE))*SEGMENT_SIZE +: SEGMENT_SIZE].
- Term evaluation:
  - term = en & AND over i of ((~pos[i] | T[i]) & (~neg[i] | ~T[i])).
  - With en=1 and no literals, the term is constant 1.
  - With pos[i] and neg[i] both set, the term is constant 0.
- Raw select = OR of its terms.
- Modes:
  - 00 LEVEL: FruSelect[j] <= raw.
  - 01 STICKY: set on raw=1, held until StickyClr. If set and clear occur in the same cycle, set wins.
  - 10 EDGE: 1-cycle pulse when raw is 1 and prev raw was 0.
  - 11 OFF: FruSelect[j] = 0.
- Latency: Trigger to FruSelect is 1 Clk (output registered).
- Shift:
  - On CfgEn, shadow <= {shadow[CFG_WIDTH-2:0], CfgBit}, so the first bit shifted ends at the MSB.
  - CfgCnt increments and saturates at CFG_WIDTH+1.
  - CfgReady = (CfgCnt == CFG_WIDTH).
- Commit: accepted only if CfgReady=1 and CfgEn=0 in the same cycle. On the next edge:
  - active <= shadow;
  - CfgCnt <= 0;
  - all sticky state and edge-history (prev raw) registers <= 0;
  - CfgErr <= 0.
- Rejected commit (CfgCnt != CFG_WIDTH, or CfgEn asserted simultaneously):
  - CfgErr <= 1;
  - active unchanged;
  - any simultaneous shift is still performed.
- Commit timing: a commit sampled at edge N updates active at edge N. FruSelect first reflects the new config at edge N+1; the value at edge N uses the old config.
- Shadow persists after commit; re-commit is possible only after a fresh full CFG_WIDTH shift.
- Reset (asynchronous, any time, including mid-shift): all of the following go to 0:
  - shadow, active, CfgCnt, sticky and prev registers;
  - FruSelect, CfgReady, CfgErr.
  - With an all-zero active config, every select is LEVEL with no terms enabled, so FruSelect = 0.
- Trigger changes while a config is being loaded have no effect on the load; outputs keep following the active config.

Decomposition:
- Package fru_pla_pkg:
  - mode enum (FRU_MODE_LEVEL/STICKY/EDGE/OFF);
  - functions or localparams for TERM_W, SEL_W, CFG_WIDTH;
  - packed term struct {en, neg, pos}.
- Sub-module fru_pla_segment:
  - purely combinational;
  - one select's NUM_TERMS terms plus OR, producing raw.
  - Instantiated OUTPUT_SIZE times via generate.
- Top-level holds the config chain, counter, commit logic and per-output mode registers.

Test Plan:
- Reset with Trigger=8'hFF -> FruSelect=0, CfgReady=0, CfgErr=0 throughout.
- Load 152 bits:
  - select0: LEVEL, term0 {en=1, pos=4'b0011, neg=4'b0100};
  - other selects OFF;
  - commit, then Trigger=8'h03 -> FruSelect=4'b0001 one cycle later;
  - Trigger=8'h07 -> 4'b0000.
- Select1 STICKY on term {en=1, pos=4'b0001} using segment 1:
  - pulse Trigger[4] for 1 cycle -> FruSelect[1] stays 1;
  - StickyClr with Trigger[4]=1 in the same cycle -> remains 1;
  - StickyClr alone -> 0 next cycle.
- Select2 EDGE: hold Trigger[0]=1 for 5 cycles -> FruSelect[2] high exactly 1 cycle.
- Commit after 151 shifts -> CfgErr=1, outputs unchanged; commit with CfgEn=1 at count 152 -> CfgErr=1, CfgCnt=153, CfgReady=0.
- Assert RstN low mid-shift (count 80) -> all outputs 0 immediately. After release, a full 152-bit load and commit works normally.
